// File: rtl/time_disp_pkg.sv
// Shared constants, types and segment table for the time display scanner.
package time_disp_pkg;

   // Field positions inside the packed 24-bit time bus
   localparam int HR_LSB  = 16;
   localparam int HR_MSB  = 20;
   localparam int MIN_LSB = 8;
   localparam int MIN_MSB = 13;
   localparam int SEC_LSB = 0;
   localparam int SEC_MSB = 5;

   // Largest legal value of each field; anything above shows dashes
   localparam logic [5:0] HR_MAX = 6'd23;
   localparam logic [5:0] MS_MAX = 6'd59;

   // Digit slot order, rightmost digit first
   typedef enum logic [2:0] {
      SEC_ONES = 3'd0,
      SEC_TENS = 3'd1,
      MIN_ONES = 3'd2,
      MIN_TENS = 3'd3,
      HR_ONES  = 3'd4,
      HR_TENS  = 3'd5
   } digit_idx_e;

   // Active-high gfedcba codes for 0..9, entry 10 is '-'
   localparam int SEG_DASH_IDX = 10;
   localparam logic [6:0] SEG_TABLE [0:10] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
      7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F, 7'h40
   };

   // One field split into two BCD digits plus its range flag
   typedef struct packed {
      logic [3:0] tens;
      logic [3:0] ones;
      logic       valid;
   } bcd_t;

   // Segment pattern for a digit; out-of-range fields render as '-'
   function automatic logic [6:0] seg_code(input logic [3:0] d, input logic ok);
      if (!ok || d > 4'd9) return SEG_TABLE[SEG_DASH_IDX];
      return SEG_TABLE[d];
   endfunction

endpackage

// File: rtl/bcd_split6.sv
// Combinational split of a 6-bit value into tens/ones with a range check.
module bcd_split6 (
   input  logic [5:0] v,
   input  logic [5:0] limit,
   output logic [3:0] tens,
   output logic [3:0] ones,
   output logic       valid
);

   // Values are at most 63, so the quotient always fits in four bits
   assign tens  = 4'(v / 6'd10);
   assign ones  = 4'(v % 6'd10);
   assign valid = (v <= limit);

endmodule

// File: rtl/time_display_scan.sv
// Six-digit multiplexed seven-segment driver for the packed time bus.
// The bus is snapshotted once per frame so a frame is never torn.
module time_display_scan
   import time_disp_pkg::*;
#(
   parameter int CLK_DIV        = 50000,
   parameter int DEAD           = 2,
   parameter int SEG_ACTIVE_LOW = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [23:0] timeBus,
   input  logic        blank,
   output logic [6:0]  seg,
   output logic        dp,
   output logic [5:0]  an,
   output logic        frame_start
);

   localparam int             CW       = $clog2(CLK_DIV);
   localparam logic [CW-1:0]  DIV_LAST = CW'(CLK_DIV - 1);
   localparam logic [CW-1:0]  DEAD_C   = CW'(DEAD);
   localparam logic           POL      = (SEG_ACTIVE_LOW != 0);
   localparam logic [5:0]     AN_OFF   = POL ? 6'h3F : 6'h00;
   localparam logic [6:0]     SEG_OFF  = POL ? 7'h7F : 7'h00;

   logic [CW-1:0]   div_cnt;
   digit_idx_e      idx;
   logic [23:0]     snap;
   logic            tick;

   logic [2:0][5:0] fld;
   logic [2:0][5:0] lim;
   bcd_t [2:0]      bcd;

   bcd_t            cur;
   logic [3:0]      digit;
   logic [6:0]      code;
   logic            dp_on;
   logic [5:0]      an_on;

   assign tick = (div_cnt == DIV_LAST);

   // Field 0 = seconds, 1 = minutes, 2 = hours; reserved bits never reach the split
   assign fld[0] = snap[SEC_MSB:SEC_LSB];
   assign fld[1] = snap[MIN_MSB:MIN_LSB];
   assign fld[2] = {1'b0, snap[HR_MSB:HR_LSB]};
   assign lim    = {HR_MAX, MS_MAX, MS_MAX};

   for (genvar f = 0; f < 3; f++) begin : g_split
      bcd_split6 u_split (
         .v     (fld[f]),
         .limit (lim[f]),
         .tens  (bcd[f].tens),
         .ones  (bcd[f].ones),
         .valid (bcd[f].valid)
      );
   end

   // Prescaler, digit index and once-per-frame snapshot
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_cnt     <= '0;
         idx         <= SEC_ONES;
         snap        <= '0;
         frame_start <= 1'b0;
      end else begin
         frame_start <= 1'b0;
         if (tick) begin
            div_cnt <= '0;
            if (idx == HR_TENS) begin
               idx         <= SEC_ONES;
               snap        <= timeBus;
               frame_start <= 1'b1;
            end else begin
               idx <= digit_idx_e'(idx + 3'd1);
            end
         end else begin
            div_cnt <= div_cnt + 1'b1;
         end
      end
   end

   // Pick the current digit's code and decide whether its anode is lit
   always_comb begin
      case (idx)
         SEC_ONES, SEC_TENS: cur = bcd[0];
         MIN_ONES, MIN_TENS: cur = bcd[1];
         default:            cur = bcd[2];
      endcase
      digit = idx[0] ? cur.tens : cur.ones;
      code  = seg_code(digit, cur.valid);
      dp_on = (idx == MIN_ONES) || (idx == HR_ONES);
      an_on = '0;
      if (!blank && (div_cnt >= DEAD_C)) an_on[idx] = 1'b1;
   end

   // Registered, polarity-corrected display outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         an  <= AN_OFF;
         seg <= SEG_OFF;
         dp  <= POL;
      end else begin
         an  <= an_on ^ {6{POL}};
         seg <= code ^ {7{POL}};
         dp  <= dp_on ^ POL;
      end
   end

endmodule
